tdm_demux_rx: RTL and testbench



---
 rtl/tdm_demux_rx.sv | 89 ++++++++
 tb/tb_tdm_demux_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_rx.sv
// TDM link receiver: deserialises CH channels of W bits (LSB first)
// followed by an even-parity bit, and presents good frames in parallel.
//
// Ports:
//   clk, rst     rising-edge clock, async active-high reset
//   bit_en       qualifies sdata/sync sampling
//   sdata        serial data / parity bit
//   sync         frame start, coincides with data bit 0
//   ch_data      last good frame, channel k at [k*W+W-1:k*W]
//   frame_valid  1-cycle pulse: ch_data loaded from a good frame
//   par_err      1-cycle pulse: frame dropped on parity mismatch
module tdm_demux_rx #(
  parameter int CH = 4,
  parameter int W  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_en,
  input  logic          sdata,
  input  logic          sync,
  output logic [CH*W-1:0] ch_data,
  output logic          frame_valid,
  output logic          par_err
);

  localparam int N  = CH * W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   sr;
  logic           acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      acc         <= 1'b0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      par_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      par_err     <= 1'b0;
      if (bit_en) begin
        if (sync) begin
          // Start (or restart) a frame from any state; a frame
          // cut short here produces no result pulse.
          sr[0] <= sdata;
          acc   <= sdata;
          cnt   <= CW'(1);
          state <= (N == 1) ? PARITY : DATA;
        end else begin
          unique case (state)
            IDLE: begin
            end
            DATA: begin
              sr[cnt] <= sdata;
              acc     <= acc ^ sdata;
              cnt     <= cnt + 1'b1;
              if (cnt == LAST)
                state <= PARITY;
            end
            PARITY: begin
              if (acc ^ sdata) begin
                par_err <= 1'b1;
              end else begin
                ch_data     <= sr;
                frame_valid <= 1'b1;
              end
              cnt   <= '0;
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Scoreboard bench for tdm_demux_rx (CH=4, W=2).
// Expected frame results are queued as driven, checked on each pulse.
module tb_tdm_demux_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       sdata;
  logic       sync;
  logic [7:0] ch_data;
  logic       frame_valid;
  logic       par_err;

  tdm_demux_rx #(.CH(4), .W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_en      (bit_en),
    .sdata       (sdata),
    .sync        (sync),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .par_err     (par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       good;
    logic [7:0] data;
    int         bitno;
  } exp_t;

  exp_t       sb[$];
  int         pulse_log[$];
  int         nvec = 0;
  int         nerr = 0;
  int         nbits = 0;
  logic [7:0] mdl_data = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk)
    if (!rst && bit_en)
      nbits++;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_valid && par_err)
        chk("both_pulses", 1, 0);
      if (frame_valid || par_err) begin
        pulse_log.push_back(nbits);
        if (sb.size() == 0) begin
          chk("spurious_pulse", {frame_valid, par_err}, 0);
        end else begin
          e = sb.pop_front();
          chk("frame_valid", frame_valid, e.good);
          chk("par_err", par_err, !e.good);
          chk("pulse_bit", nbits, e.bitno);
          chk("ch_data", ch_data, e.good ? e.data : mdl_data);
          if (e.good)
            mdl_data = e.data;
        end
      end else if (ch_data !== mdl_data) begin
        chk("ch_data_hold", ch_data, mdl_data);
      end
    end
  end

  task automatic send_bit(input logic b, input logic s, input int gap);
    @(negedge clk);
    bit_en = 1'b1;
    sdata  = b;
    sync   = s;
    repeat (gap) begin
      @(negedge clk);
      bit_en = 1'b0;
      sdata  = 1'($urandom);
      sync   = 1'($urandom);
    end
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic flip,
                            input int gap);
    exp_t e;
    for (int i = 0; i < 8; i++)
      send_bit(d[i], i == 0, gap);
    @(negedge clk);
    bit_en  = 1'b1;
    sdata   = (^d) ^ flip;
    sync    = 1'b0;
    e.good  = !flip;
    e.data  = d;
    e.bitno = nbits + 1;
    sb.push_back(e);
    repeat (gap) begin
      @(negedge clk);
      bit_en = 1'b0;
      sdata  = 1'($urandom);
      sync   = 1'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_en = 1'b0;
      sync   = 1'b0;
      sdata  = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] part;
    int p0;
    rst    = 1'b1;
    bit_en = 1'b0;
    sdata  = 1'b0;
    sync   = 1'b0;
    #12;
    chk("rst_ch_data", ch_data, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_pe", par_err, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Good frame A5, continuous enable
    send_frame(8'hA5, 1'b0, 0);
    idle(3);
    drain();

    // Same data, bad parity: ch_data holds
    send_frame(8'hA5, 1'b1, 0);
    idle(3);
    drain();

    // Gapped bits
    send_frame(8'h3C, 1'b0, 2);
    idle(3);
    drain();

    // Resync after 5 bits
    part = 8'h5A;
    for (int i = 0; i < 5; i++)
      send_bit(part[i], i == 0, 0);
    send_frame(8'hFF, 1'b0, 0);
    idle(3);
    drain();

    // Back-to-back
    p0 = pulse_log.size();
    send_frame(8'h01, 1'b0, 0);
    send_frame(8'h80, 1'b0, 0);
    idle(3);
    drain();
    chk("b2b_count", pulse_log.size() - p0, 2);
    if (pulse_log.size() - p0 == 2)
      chk("b2b_spacing", pulse_log[p0+1] - pulse_log[p0], 9);

    // Reset mid-frame
    part = 8'hC3;
    for (int i = 0; i < 4; i++)
      send_bit(part[i], i == 0, 0);
    @(negedge clk);
    bit_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ch_data", ch_data, 0);
    chk("mid_rst_fv", frame_valid, 0);
    chk("mid_rst_pe", par_err, 0);
    mdl_data = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 4; i < 8; i++)
      send_bit(part[i], 1'b0, 0);
    send_bit(^part, 1'b0, 0);
    idle(4);
    chk("no_pulse_after_rst", sb.size(), 0);

    // Recovery
    send_frame(8'h96, 1'b0, 1);
    idle(3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
